router_pkt_fifo: RTL

Parametrised, packet-aware synchronous FIFO for the router's per-destination output channels. Stores each byte with a start-of-packet tag and tracks the remaining length of the packet being read, so the read side knows when a packet ends. Adds occupancy, almost-full and end-of-packet outputs, and drives no tristate values. One instance per output port sits between the router FSM/synchroniser and the port's read interface.

---
 rtl/router_pkg.sv | 15 +
 rtl/router_fifo_ram.sv | 30 +++
 rtl/router_pkt_fifo.sv | 120 ++++++++++++
 3 files changed

// File: rtl/router_pkg.sv
// Shared router definitions: default byte width, header length field
// position and the header length extraction helper.
package router_pkg;

    localparam int DATA_W_DEF  = 8;
    localparam int LEN_MSB_DEF = 7;
    localparam int LEN_LSB_DEF = 2;
    localparam int LEN_W_DEF   = LEN_MSB_DEF - LEN_LSB_DEF + 1;

    // Payload length carried in a default-layout header byte.
    function automatic logic [LEN_W_DEF-1:0] hdr_len(input logic [7:0] hdr);
        return hdr[LEN_MSB_DEF:LEN_LSB_DEF];
    endfunction

endpackage

// File: rtl/router_fifo_ram.sv
// Simple dual-port storage array: one write port, one registered read port.
// No reset; contents survive resets and flushes.
module router_fifo_ram #(
    parameter int W  = 9,
    parameter int AW = 4
) (
    input  logic          clock,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [0:(1<<AW)-1];

    // Write port.
    always_ff @(posedge clock) begin
        if (we)
            mem[waddr] <= wdata;
    end

    // Registered read; holds its last value when no read is issued.
    always_ff @(posedge clock) begin
        if (re)
            rdata <= mem[raddr];
    end

endmodule

// File: rtl/router_pkt_fifo.sv
// Packet-aware synchronous FIFO for one router output channel. Each entry
// carries a byte plus a start-of-packet tag; the read side tracks the
// remaining length of the current packet to flag its last (parity) byte.
module router_pkt_fifo
    import router_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int DEPTH     = 16,
    parameter int LEN_MSB   = LEN_MSB_DEF,
    parameter int LEN_LSB   = LEN_LSB_DEF,
    parameter int AFULL_LVL = DEPTH - 2
) (
    input  logic                     clock,
    input  logic                     resetn,
    input  logic                     soft_reset,
    input  logic                     write_enb,
    input  logic                     sof_in,
    input  logic [DATA_W-1:0]        data_in,
    input  logic                     read_enb,
    output logic [DATA_W-1:0]        data_out,
    output logic                     data_valid,
    output logic                     sof_out,
    output logic                     eop,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int AW    = $clog2(DEPTH);
    localparam int LEN_W = LEN_MSB - LEN_LSB + 1;
    localparam int RW    = LEN_W + 1;

    logic [AW:0]     wr_ptr;
    logic [AW:0]     rd_ptr;
    logic [RW-1:0]   rem_cnt;
    logic            out_clr;
    logic [DATA_W:0] ram_q;
    logic            clr;
    logic            wr_ok;
    logic            rd_ok;
    logic            hdr_tag;
    logic [LEN_W-1:0] len_fld;

    assign clr   = !resetn || soft_reset;
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign empty = (wr_ptr == rd_ptr);
    assign wr_ok = !clr && write_enb && !full;
    assign rd_ok = !clr && read_enb && !empty;

    router_fifo_ram #(
        .W  (DATA_W + 1),
        .AW (AW)
    ) u_ram (
        .clock (clock),
        .we    (wr_ok),
        .waddr (wr_ptr[AW-1:0]),
        .wdata ({sof_in, data_in}),
        .re    (rd_ok),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (ram_q)
    );

    // Read and write pointers, flushed by either reset.
    always_ff @(posedge clock) begin
        if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Dedicated occupancy counter tracking accepted pushes and pops.
    always_ff @(posedge clock) begin
        if (clr)
            occupancy <= '0;
        else if (wr_ok && !rd_ok)
            occupancy <= occupancy + 1'b1;
        else if (rd_ok && !wr_ok)
            occupancy <= occupancy - 1'b1;
    end

    // Read-side qualifiers: valid pulse and the forced-zero data view after a flush.
    always_ff @(posedge clock) begin
        if (clr) begin
            data_valid <= 1'b0;
            out_clr    <= 1'b1;
        end else begin
            data_valid <= rd_ok;
            if (rd_ok)
                out_clr <= 1'b0;
        end
    end

    // The RAM has no reset, so data_out reads as zero until the first pop
    // after a reset or flush.
    assign data_out    = out_clr ? '0 : ram_q[DATA_W-1:0];
    assign hdr_tag     = ram_q[DATA_W];
    assign len_fld     = ram_q[LEN_MSB:LEN_LSB];
    assign sof_out     = data_valid && hdr_tag;
    assign eop         = data_valid && !hdr_tag && (rem_cnt == RW'(1));
    assign almost_full = (occupancy >= (AW+1)'(AFULL_LVL));

    // Packet tracker, advanced by the byte presented on data_out this cycle.
    always_ff @(posedge clock) begin
        if (clr)
            rem_cnt <= '0;
        else if (data_valid) begin
            if (hdr_tag)
                rem_cnt <= {1'b0, len_fld} + RW'(1);
            else if (rem_cnt != '0)
                rem_cnt <= rem_cnt - RW'(1);
        end
    end

endmodule
